// File: rtl/hub75_row_monitor.sv
// HUB75 drive-signal monitor: oversamples bclk/rgb/addr/oe/le, rebuilds each latched row
// and streams it out tagged with address and bit-plane. Optional macro: HUB75_OE_TIMING_EN.
module hub75_row_monitor #(
  parameter int NUM_COLS = 64,
  parameter int CHAIN    = 1,
  parameter int ADDR_W   = 4,
  parameter int PLANE_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       bclk_in,
  input  logic [2:0]                 rgb_top_in,
  input  logic [2:0]                 rgb_bot_in,
  input  logic [ADDR_W-1:0]          addr_in,
  input  logic                       oe_n_in,
  input  logic                       le_in,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [3*NUM_COLS*CHAIN-1:0] row_top,
  output logic [3*NUM_COLS*CHAIN-1:0] row_bot,
  output logic [ADDR_W-1:0]          row_addr,
  output logic [PLANE_W-1:0]         row_plane,
  output logic [CNT_W-1:0]           row_oe_cycles,
  output logic                       err_len,
  output logic                       err_overflow
);

  localparam int               L       = NUM_COLS * CHAIN;
  localparam logic [CNT_W-1:0] L_CNT   = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchroniser chains: index 0 is the first flop, index 2 the edge-detect flop.
  logic [2:0]        bclk_sync;
  logic [2:0]        le_sync;
  logic [2:0]        rgb_top_d1, rgb_top_d2;
  logic [2:0]        rgb_bot_d1, rgb_bot_d2;
  logic [ADDR_W-1:0] addr_d1, addr_d2;

  logic bclk_rise;
  logic le_rise;

  // Colour-major shift registers: [0]=red, [1]=green, [2]=blue, so flattening gives {b,g,r}.
  logic [2:0][L-1:0] sr_top, sr_bot;
  logic [2:0][L-1:0] shift_top, shift_bot;
  logic [CNT_W-1:0]  bit_cnt, cnt_eff;

  logic [ADDR_W-1:0]  prev_addr;
  logic               prev_valid;
  logic [PLANE_W-1:0] plane, plane_next;
  logic               load;

  // NOTE: every clocked block uses non-blocking assignments so flops read pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bclk_sync  <= '0;
      le_sync    <= '0;
      rgb_top_d1 <= '0;
      rgb_top_d2 <= '0;
      rgb_bot_d1 <= '0;
      rgb_bot_d2 <= '0;
      addr_d1    <= '0;
      addr_d2    <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[1:0], bclk_in};
      le_sync    <= {le_sync[1:0], le_in};
      rgb_top_d1 <= rgb_top_in;
      rgb_top_d2 <= rgb_top_d1;
      rgb_bot_d1 <= rgb_bot_in;
      rgb_bot_d2 <= rgb_bot_d1;
      addr_d1    <= addr_in;
      addr_d2    <= addr_d1;
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign le_rise   = le_sync[1] & ~le_sync[2];

  // Post-shift view of this cycle, so a latch coinciding with a bclk rise sees the new bit.
  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    shift_top = sr_top;
    shift_bot = sr_bot;
    cnt_eff   = bit_cnt;
    if (bclk_rise) begin
      for (int c = 0; c < 3; c++) begin
        shift_top[c] = {sr_top[c][L-2:0], rgb_top_d2[c]};
        shift_bot[c] = {sr_bot[c][L-2:0], rgb_bot_d2[c]};
      end
      cnt_eff = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
    end
    plane_next = (prev_valid && (addr_d2 == prev_addr)) ? plane + 1'b1 : '0;
    load       = le_rise && (!row_valid || row_ready);
  end

  // NOTE: the shift registers are reset explicitly so a reset mid-row discards the partial row.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sr_top     <= '0;
      sr_bot     <= '0;
      bit_cnt    <= '0;
      prev_addr  <= '0;
      prev_valid <= 1'b0;
      plane      <= '0;
    end else begin
      sr_top  <= shift_top;
      sr_bot  <= shift_bot;
      bit_cnt <= le_rise ? '0 : cnt_eff;
      if (le_rise) begin
        prev_addr  <= addr_d2;
        prev_valid <= 1'b1;
        plane      <= plane_next;
      end
    end
  end

  // Single holding register; a latch while the consumer is stalling drops the new row.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      row_valid    <= 1'b0;
      row_top      <= '0;
      row_bot      <= '0;
      row_addr     <= '0;
      row_plane    <= '0;
      err_len      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_len      <= le_rise && (cnt_eff != L_CNT);
      err_overflow <= le_rise && row_valid && !row_ready;
      if (load) begin
        row_valid <= 1'b1;
        row_top   <= shift_top;
        row_bot   <= shift_bot;
        row_addr  <= addr_d2;
        row_plane <= plane_next;
      end else if (row_ready) begin
        row_valid <= 1'b0;
      end
    end
  end

`ifdef HUB75_OE_TIMING_EN
  logic [1:0]       oe_n_sync;
  logic [CNT_W-1:0] oe_cnt;
  logic [CNT_W-1:0] oe_hold;

  // Enabled time accumulates between latches; the count travels with the row it precedes.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      oe_n_sync <= 2'b11;
      oe_cnt    <= '0;
      oe_hold   <= '0;
    end else begin
      oe_n_sync <= {oe_n_sync[0], oe_n_in};
      if (le_rise) begin
        oe_cnt <= '0;
      end else if (!oe_n_sync[1] && (oe_cnt != CNT_MAX)) begin
        oe_cnt <= oe_cnt + 1'b1;
      end
      if (load) begin
        oe_hold <= oe_cnt;
      end
    end
  end

  assign row_oe_cycles = oe_hold;
`else
  logic unused_oe_n;
  assign unused_oe_n   = oe_n_in;
  assign row_oe_cycles = '0;
`endif

endmodule

// File: tb/tb_hub75_row_monitor.sv
// Directed bench for hub75_row_monitor: a CHAIN=1 instance for most scenarios and a
// CHAIN=2 instance sharing the drive pins for the 128-bit / coincident bclk+le case.
module tb_hub75_row_monitor;

  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       bclk;
  logic [2:0] rgb_top, rgb_bot;
  logic [3:0] addr;
  logic       oe_n, le;
  logic       row_ready, row_ready2;

  logic             row_valid, err_len, err_overflow;
  logic [191:0]     row_top, row_bot;
  logic [3:0]       row_addr;
  logic [2:0]       row_plane;
  logic [CNT_W-1:0] row_oe_cycles;

  logic             row_valid2, err_len2, err_overflow2;
  logic [383:0]     row_top2, row_bot2;
  logic [3:0]       row_addr2;
  logic [2:0]       row_plane2;
  logic [CNT_W-1:0] row_oe_cycles2;

  int checks = 0;
  int errors = 0;

  logic [63:0]  pat;
  logic [127:0] pat2;
  logic [CNT_W-1:0] oe_expect;

  always #5 clk = ~clk;

  hub75_row_monitor #(.NUM_COLS(64), .CHAIN(1)) dut (
    .clk(clk), .n_reset(n_reset), .bclk_in(bclk), .rgb_top_in(rgb_top), .rgb_bot_in(rgb_bot),
    .addr_in(addr), .oe_n_in(oe_n), .le_in(le), .row_valid(row_valid), .row_ready(row_ready),
    .row_top(row_top), .row_bot(row_bot), .row_addr(row_addr), .row_plane(row_plane),
    .row_oe_cycles(row_oe_cycles), .err_len(err_len), .err_overflow(err_overflow)
  );

  hub75_row_monitor #(.NUM_COLS(64), .CHAIN(2)) dut2 (
    .clk(clk), .n_reset(n_reset), .bclk_in(bclk), .rgb_top_in(rgb_top), .rgb_bot_in(rgb_bot),
    .addr_in(addr), .oe_n_in(oe_n), .le_in(le), .row_valid(row_valid2), .row_ready(row_ready2),
    .row_top(row_top2), .row_bot(row_bot2), .row_addr(row_addr2), .row_plane(row_plane2),
    .row_oe_cycles(row_oe_cycles2), .err_len(err_len2), .err_overflow(err_overflow2)
  );

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit: top red carries the pattern bit, bottom blue carries its inverse.
  task automatic send_bit(input logic b);
    rgb_top = {2'b00, b};
    rgb_bot = {~b, 2'b00};
    bclk = 1'b0;
    tick(2);
    bclk = 1'b1;
    tick(2);
  endtask

  // Shifts pat[n-1] first down to pat[0] last.
  task automatic shift_bits(input int n, input logic [127:0] p);
    for (int i = n - 1; i >= 0; i--) send_bit(p[i]);
  endtask

  // Raise le and return just after the 3rd posedge, when the row should be visible.
  task automatic latch_rise();
    @(negedge clk);
    le = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Release le, accept the held row, and confirm valid and err_len drop.
  task automatic consume(input string tag);
    @(negedge clk);
    le = 1'b0;
    row_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, row_valid, 1'b0);
    check({tag, "_err_len_low"}, err_len, 1'b0);
    @(negedge clk);
    row_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bclk = 1'b0;
    le = 1'b0;
    tick(2);
    n_reset = 1'b0;
    tick(2);
    n_reset = 1'b1;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0; bclk = 1'b0; rgb_top = '0; rgb_bot = '0; addr = '0;
    oe_n = 1'b1; le = 1'b0; row_ready = 1'b0; row_ready2 = 1'b0;
    tick(3);
    check("reset_valid", row_valid, 1'b0);
    check("reset_top", row_top, '0);
    check("reset_plane", row_plane, '0);
    check("reset_errs", {err_len, err_overflow}, 2'b00);
    n_reset = 1'b1;
    tick(2);

    // 1: full row at addr 5, red = 1010...
    addr = 4'd5;
    pat = 64'hAAAA_AAAA_AAAA_AAAA;
    shift_bits(64, {64'h0, pat});
    latch_rise();
    check("t1_valid", row_valid, 1'b1);
    check("t1_top", row_top, {128'h0, pat});
    check("t1_bot", row_bot, {~pat, 128'h0});
    check("t1_addr", row_addr, 4'd5);
    check("t1_plane", row_plane, 3'd0);
    check("t1_err_len", err_len, 1'b0);
    consume("t1");

    // 2: 63 bits only -> err_len pulse, row still delivered with bit 63 at reset value
    do_reset();
    addr = 4'd7;
    pat = 64'h7FFF_FFFF_FFFF_FFFF;
    shift_bits(63, {64'h0, pat});
    latch_rise();
    check("t2_valid", row_valid, 1'b1);
    check("t2_err_len", err_len, 1'b1);
    check("t2_top", row_top, {128'h0, pat});
    check("t2_bot", row_bot, '0);
    consume("t2");

    // 3: ten latches at addr 2 then one at addr 3
    for (int i = 0; i < 11; i++) begin
      addr = (i < 10) ? 4'd2 : 4'd3;
      pat = {32'h1357_9BDF, 32'(i)};
      shift_bits(64, {64'h0, pat});
      latch_rise();
      check($sformatf("t3_plane_%0d", i), row_plane, (i < 10) ? 3'(i % 8) : 3'd0);
      check($sformatf("t3_flags_%0d", i), {row_valid, err_len, err_overflow}, 3'b100);
      check($sformatf("t3_addr_%0d", i), row_addr, (i < 10) ? 4'd2 : 4'd3);
      consume($sformatf("t3_%0d", i));
    end

    // 4: consumer stalled across two latches
    addr = 4'd1;
    pat = 64'hFFFF_FFFF_FFFF_FFFF;
    shift_bits(64, {64'h0, pat});
    latch_rise();
    check("t4_row1_valid", row_valid, 1'b1);
    @(negedge clk);
    le = 1'b0;
    addr = 4'd4;
    shift_bits(64, 128'h0);
    latch_rise();
    check("t4_overflow", err_overflow, 1'b1);
    check("t4_held_top", row_top, {128'h0, pat});
    check("t4_held_addr", row_addr, 4'd1);
    check("t4_held_plane", row_plane, 3'd0);
    check("t4_still_valid", row_valid, 1'b1);
    @(posedge clk);
    #1;
    check("t4_overflow_pulse_end", err_overflow, 1'b0);
    consume("t4");

    // 5: reset in the middle of a row, then a clean row
    shift_bits(30, {128{1'b1}});
    do_reset();
    check("t5_reset_valid", row_valid, 1'b0);
    check("t5_reset_top", row_top, '0);
    addr = 4'd9;
    pat = 64'h0123_4567_89AB_CDEF;
    shift_bits(64, {64'h0, pat});
    latch_rise();
    check("t5_err_len", err_len, 1'b0);
    check("t5_top", row_top, {128'h0, pat});
    check("t5_addr", row_addr, 4'd9);
    consume("t5");

    // 6: output enabled for 100 clk between latches
    @(negedge clk);
    oe_n = 1'b0;
    tick(100);
    oe_n = 1'b1;
    tick(4);
    shift_bits(64, {64'h0, pat});
    latch_rise();
`ifdef HUB75_OE_TIMING_EN
    oe_expect = 16'd100;
`else
    oe_expect = 16'd0;
`endif
    check("t6_oe_cycles", row_oe_cycles, oe_expect);
    consume("t6");

    // 7: CHAIN=2, final bclk rise coincident with le
    do_reset();
    addr = 4'd6;
    pat2 = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA99};
    for (int i = 127; i >= 1; i--) send_bit(pat2[i]);
    rgb_top = {2'b00, pat2[0]};
    rgb_bot = {~pat2[0], 2'b00};
    bclk = 1'b0;
    tick(2);
    bclk = 1'b1;
    le = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t7_valid", row_valid2, 1'b1);
    check("t7_err_len", err_len2, 1'b0);
    check("t7_top", row_top2, {256'h0, pat2});
    check("t7_bot", row_bot2, {~pat2, 256'h0});
    check("t7_addr", row_addr2, 4'd6);
    @(negedge clk);
    le = 1'b0;
    bclk = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
